stream_deserializer: RTL and testbench

Collects a narrow valid/ready element stream into wide words, least-significant element first. It is the receive-side partner of the element serializer in the common library and sits on any datapath that must widen a bus. It supports short, partial words terminated by a last flag, and reports how many elements each output word holds. Both sides use valid/ready handshakes with full backpressure and no data loss.

---
 rtl/stream_deserializer.sv | 110 +++++++++++
 tb/tb_stream_deserializer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_deserializer.sv
// Packs a narrow valid/ready element stream into wide words, LSB element first.
// Words close on the last lane or on elem_last_i; each word reports its element count.
module stream_deserializer #(
    parameter  int ELEM_WIDTH = 8,
    parameter  int NUM_ELEM   = 4,
    localparam int WORD_WIDTH = ELEM_WIDTH * NUM_ELEM,
    localparam int CNT_WIDTH  = $clog2(NUM_ELEM + 1)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  clear_i,
    input  logic [ELEM_WIDTH-1:0] elem_i,
    input  logic                  elem_last_i,
    input  logic                  elem_valid_i,
    output logic                  elem_ready_o,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic [CNT_WIDTH-1:0]  word_count_o,
    output logic                  word_last_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i
);
    localparam int IDX_WIDTH = $clog2(NUM_ELEM);

    if (NUM_ELEM < 2 || ELEM_WIDTH < 1) begin : g_param_check
        $error("stream_deserializer: NUM_ELEM must be >= 2 and ELEM_WIDTH >= 1");
    end

    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;

    logic                  at_top;
    logic                  accept;
    logic                  complete;
    logic [WORD_WIDTH-1:0] merged;

    assign at_top = (idx_q == IDX_WIDTH'(NUM_ELEM - 1));

    // Non-completing beats never touch the output register, so they may
    // proceed while the output is stalled.
    assign elem_ready_o = arst_ni & ~clear_i &
                          (~valid_q | word_ready_i | (~elem_last_i & ~at_top));
    assign accept   = elem_valid_i & elem_ready_o;
    assign complete = accept & (elem_last_i | at_top);

    // Accumulator lanes above idx_q are always zero, so merging keeps
    // unfilled upper elements of a partial word at zero.
    always_comb begin
        merged = acc_q;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (idx_q == IDX_WIDTH'(i)) merged[i*ELEM_WIDTH +: ELEM_WIDTH] = elem_i;
        end
    end

    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        word_d  = word_q;
        count_d = count_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (clear_i) begin
            idx_d   = '0;
            acc_d   = '0;
            word_d  = '0;
            count_d = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            if (valid_q && word_ready_i) valid_d = 1'b0;
            if (complete) begin
                word_d  = merged;
                count_d = CNT_WIDTH'(idx_q) + CNT_WIDTH'(1);
                last_d  = elem_last_i;
                valid_d = 1'b1;
                idx_d   = '0;
                acc_d   = '0;
            end else if (accept) begin
                acc_d = merged;
                idx_d = idx_q + IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            idx_q   <= '0;
            acc_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            count_q <= count_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_count_o = count_q;
    assign word_last_o  = last_q;
    assign word_valid_o = valid_q;
endmodule

// File: tb/tb_stream_deserializer.sv
// Randomized bench for stream_deserializer: a queue-based word model checks
// every cycle, and scenario tasks check the directed cases.
module tb_stream_deserializer;
    localparam int EW = 8;
    localparam int NE = 4;
    localparam int WW = EW * NE;
    localparam int CW = $clog2(NE + 1);

    logic          clk_i = 1'b0;
    logic          arst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic [EW-1:0] elem_i = '0;
    logic          elem_last_i = 1'b0;
    logic          elem_valid_i = 1'b0;
    logic          elem_ready_o;
    logic [WW-1:0] word_o;
    logic [CW-1:0] word_count_o;
    logic          word_last_o;
    logic          word_valid_o;
    logic          word_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    stream_deserializer #(.ELEM_WIDTH(EW), .NUM_ELEM(NE)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .clear_i(clear_i),
        .elem_i(elem_i), .elem_last_i(elem_last_i), .elem_valid_i(elem_valid_i),
        .elem_ready_o(elem_ready_o), .word_o(word_o), .word_count_o(word_count_o),
        .word_last_o(word_last_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a list of pending elements and one held output word.
    logic [EW-1:0] part[$];
    bit            held_v = 0;
    logic [WW-1:0] held_w = '0;
    int            held_c = 0;
    bit            held_l = 0;

    always @(negedge clk_i) begin
        bit exp_ready;
        if (!arst_ni) begin
            part.delete();
            held_v = 0;
            checks++;
            if (elem_ready_o !== 1'b0 || word_valid_o !== 1'b0 || word_o !== '0 ||
                word_count_o !== '0 || word_last_o !== 1'b0) begin
                errors++;
                $display("FAIL model_reset: ready=%b valid=%b word=%h cnt=%0d last=%b, want all 0",
                         elem_ready_o, word_valid_o, word_o, word_count_o, word_last_o);
            end
        end else begin
            exp_ready = !clear_i && (!held_v || word_ready_i ||
                        (!elem_last_i && part.size() < NE - 1));
            checks++;
            if (elem_ready_o !== exp_ready) begin
                errors++;
                $display("FAIL model_ready: got %b want %b", elem_ready_o, exp_ready);
            end
            checks++;
            if (word_valid_o !== held_v) begin
                errors++;
                $display("FAIL model_valid: got %b want %b", word_valid_o, held_v);
            end else if (held_v && (word_o !== held_w || word_count_o !== CW'(held_c) ||
                                    word_last_o !== held_l)) begin
                errors++;
                $display("FAIL model_word: got %h/%0d/%b want %h/%0d/%b",
                         word_o, word_count_o, word_last_o, held_w, held_c, held_l);
            end
            if (clear_i) begin
                part.delete();
                held_v = 0;
            end else begin
                if (held_v && word_ready_i) held_v = 0;
                if (elem_valid_i && exp_ready) begin
                    part.push_back(elem_i);
                    if (elem_last_i || part.size() == NE) begin
                        held_w = '0;
                        foreach (part[i]) held_w[i*EW +: EW] = part[i];
                        held_c = part.size();
                        held_l = elem_last_i;
                        held_v = 1;
                        part.delete();
                    end
                end
            end
        end
    end

    // Present one element and return one cycle (+1) after it is accepted.
    task automatic beat(input logic [EW-1:0] d, input logic l);
        int n = 0;
        elem_i = d; elem_last_i = l; elem_valid_i = 1'b1;
        @(negedge clk_i);
        while (!elem_ready_o && n < 50) begin n++; @(negedge clk_i); end
        if (n >= 50) begin
            errors++;
            $display("FAIL beat_timeout: element %h never accepted", d);
        end
        @(posedge clk_i); #1;
        elem_valid_i = 1'b0; elem_last_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (word_o !== '0 || word_count_o !== '0 || word_valid_o !== 1'b0 ||
            word_last_o !== 1'b0 || elem_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: word=%h cnt=%0d valid=%b last=%b ready=%b",
                     word_o, word_count_o, word_valid_o, word_last_o, elem_ready_o);
        end
        idle(2);
        arst_ni = 1'b1;
        idle(1);
    endtask

    task automatic test_full_word();
        word_ready_i = 1'b1;
        beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
        checks++;
        if (word_valid_o !== 1'b1 || word_o !== 32'h44332211 || word_count_o !== 3'd4 ||
            word_last_o !== 1'b0) begin
            errors++;
            $display("FAIL full_word: got v=%b %h/%0d/%b want v=1 44332211/4/0",
                     word_valid_o, word_o, word_count_o, word_last_o);
        end
        idle(1);
        checks++;
        if (word_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_word_pulse: valid=%b want 0", word_valid_o);
        end
    endtask

    task automatic test_partial();
        word_ready_i = 1'b1;
        beat(8'hAA, 0); beat(8'hBB, 1);
        checks++;
        if (word_valid_o !== 1'b1 || word_o !== 32'h0000BBAA || word_count_o !== 3'd2 ||
            word_last_o !== 1'b1) begin
            errors++;
            $display("FAIL partial_word: got v=%b %h/%0d/%b want v=1 0000bbaa/2/1",
                     word_valid_o, word_o, word_count_o, word_last_o);
        end
        beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
        checks++;
        if (word_o !== 32'h04030201 || word_count_o !== 3'd4 || word_last_o !== 1'b0) begin
            errors++;
            $display("FAIL partial_restart: got %h/%0d/%b want 04030201/4/0",
                     word_o, word_count_o, word_last_o);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        word_ready_i = 1'b0;
        for (int i = 1; i <= 7; i++) beat(EW'(i), 0);
        elem_i = 8'h08; elem_last_i = 1'b0; elem_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            checks++;
            if (elem_ready_o !== 1'b0 || word_valid_o !== 1'b1 || word_o !== 32'h04030201) begin
                errors++;
                $display("FAIL bp_hold: ready=%b valid=%b word=%h want 0/1/04030201",
                         elem_ready_o, word_valid_o, word_o);
            end
        end
        @(posedge clk_i); #1;
        word_ready_i = 1'b1;
        #1;
        checks++;
        if (elem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb: ready=%b want 1", elem_ready_o);
        end
        @(posedge clk_i); #1;
        elem_valid_i = 1'b0;
        checks++;
        if (word_valid_o !== 1'b1 || word_o !== 32'h08070605 || word_count_o !== 3'd4) begin
            errors++;
            $display("FAIL bp_second: got v=%b %h/%0d want v=1 08070605/4",
                     word_valid_o, word_o, word_count_o);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        word_ready_i = 1'b1;
        for (int k = 0; k < 3 * NE; k++) begin
            elem_i = EW'($urandom); elem_last_i = 1'b0; elem_valid_i = 1'b1;
            #1;
            checks++;
            if (elem_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready: beat %0d ready=%b want 1", k, elem_ready_o);
            end
            @(posedge clk_i); #1;
            checks++;
            if (word_valid_o !== (k % NE == NE - 1)) begin
                errors++;
                $display("FAIL stream_valid: beat %0d valid=%b want %b",
                         k, word_valid_o, (k % NE == NE - 1));
            end
        end
        elem_valid_i = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_mid();
        word_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) beat(EW'(i), 0);
        beat(8'h11, 0); beat(8'h22, 0);
        #2 arst_ni = 1'b0;
        #1;
        checks++;
        if (word_valid_o !== 1'b0 || word_o !== '0 || word_count_o !== '0 ||
            word_last_o !== 1'b0 || elem_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid=%b word=%h cnt=%0d last=%b ready=%b want all 0",
                     word_valid_o, word_o, word_count_o, word_last_o, elem_ready_o);
        end
        @(posedge clk_i); #1;
        arst_ni = 1'b1;
        word_ready_i = 1'b1;
        idle(1);
        beat(8'h55, 0); beat(8'h66, 0); beat(8'h77, 0); beat(8'h88, 0);
        checks++;
        if (word_valid_o !== 1'b1 || word_o !== 32'h88776655 || word_count_o !== 3'd4) begin
            errors++;
            $display("FAIL reset_recover: got v=%b %h/%0d want v=1 88776655/4",
                     word_valid_o, word_o, word_count_o);
        end
        idle(2);
    endtask

    task automatic test_clear();
        logic [WW-1:0] exp_w;
        word_ready_i = 1'b0;
        beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
        beat(8'hA1, 0); beat(8'hA2, 0);
        clear_i = 1'b1; elem_i = 8'hEE; elem_last_i = 1'b1; elem_valid_i = 1'b1;
        #1;
        checks++;
        if (elem_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: ready=%b want 0", elem_ready_o);
        end
        @(posedge clk_i); #1;
        clear_i = 1'b0; elem_valid_i = 1'b0; elem_last_i = 1'b0;
        checks++;
        if (word_valid_o !== 1'b0 || word_count_o !== '0 || word_last_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_out: valid=%b cnt=%0d last=%b want 0/0/0",
                     word_valid_o, word_count_o, word_last_o);
        end
        word_ready_i = 1'b1;
        exp_w = '0;
        for (int i = 0; i < NE; i++) begin
            logic [EW-1:0] d;
            d = EW'($urandom);
            exp_w[i*EW +: EW] = d;
            beat(d, 0);
        end
        checks++;
        if (word_valid_o !== 1'b1 || word_o !== exp_w || word_count_o !== 3'd4) begin
            errors++;
            $display("FAIL clear_recover: got v=%b %h/%0d want v=1 %h/4",
                     word_valid_o, word_o, word_count_o, exp_w);
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            elem_i       = EW'($urandom);
            elem_valid_i = ($urandom_range(0, 99) < 70);
            elem_last_i  = ($urandom_range(0, 99) < 20);
            word_ready_i = ($urandom_range(0, 99) < 60);
            clear_i      = ($urandom_range(0, 99) < 3);
            @(posedge clk_i); #1;
        end
        elem_valid_i = 1'b0; clear_i = 1'b0; word_ready_i = 1'b1;
        idle(3);
        checks++;
        if (word_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: valid=%b want 0", word_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
